// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light sequencer: state codes,
// GRB lamp colours, lamp slot positions and the per-slot lamp table.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_GREEN      = 3'd1,
        ST_YELLOW     = 3'd2,
        ST_RED        = 3'd3,
        ST_RED_YELLOW = 3'd4,
        ST_NIGHT_ON   = 3'd5,
        ST_NIGHT_OFF  = 3'd6
    } state_t;

    localparam logic [23:0] COLOR_RED   = 24'h00FF00;
    localparam logic [23:0] COLOR_AMBER = 24'hA5FF00;
    localparam logic [23:0] COLOR_GREEN = 24'hFF0000;
    localparam logic [23:0] COLOR_OFF   = 24'h000000;

    localparam int SLOT_RED   = 0;
    localparam int SLOT_AMBER = 1;
    localparam int SLOT_GREEN = 2;
    localparam int SLOT_PED   = 3;

    function automatic logic is_day(state_t s);
        return !(s inside {ST_NIGHT_ON, ST_NIGHT_OFF});
    endfunction

    // Slots beyond the pedestrian lamp are always dark.
    function automatic logic [23:0] lamp_color(state_t s, int slot);
        logic [23:0] c;
        c = COLOR_OFF;
        case (slot)
            SLOT_RED:   if (s inside {ST_INIT, ST_RED, ST_RED_YELLOW}) c = COLOR_RED;
            SLOT_AMBER: if (s inside {ST_YELLOW, ST_RED_YELLOW, ST_NIGHT_ON}) c = COLOR_AMBER;
            SLOT_GREEN: if (s == ST_GREEN) c = COLOR_GREEN;
            SLOT_PED: begin
                if (s == ST_RED)   c = COLOR_GREEN;
                else if (is_day(s)) c = COLOR_RED;
            end
            default:    c = COLOR_OFF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_gen.sv
// Prescaler producing one tick every DIV clocks; hold freezes it, clear
// restarts the count so a new phase always begins on a fresh tick period.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int PW = $clog2(DIV);

    logic [PW-1:0] count;

    assign tick = !hold && (count == PW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (!hold)
            count <= tick ? '0 : count + PW'(1);
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Traffic-light sequencer: phase timing, pedestrian request latch, night
// blinking and GRB pixel packing for the LED-strip serialiser.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int CLK_HZ           = 100_000_000,
    parameter int TICK_HZ          = 10,
    parameter int NUM_LEDS         = 4,
    parameter int INIT_TICKS       = 20,
    parameter int GREEN_TICKS      = 50,
    parameter int PED_MIN_GREEN    = 20,
    parameter int YELLOW_TICKS     = 10,
    parameter int RED_TICKS        = 50,
    parameter int RED_YELLOW_TICKS = 10,
    parameter int BLINK_TICKS      = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    night_mode,
    input  logic                    ped_req,
    input  logic                    hold,
    output logic [NUM_LEDS*24-1:0]  colordata,
    output logic                    frame_update,
    output logic [2:0]              phase,
    output logic                    ped_ack
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int OUT_W = NUM_LEDS * 24;

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_TICKS = max2(max2(max2(INIT_TICKS, GREEN_TICKS), max2(YELLOW_TICKS, RED_TICKS)),
                                    max2(RED_YELLOW_TICKS, BLINK_TICKS));
    localparam int CW        = $clog2(MAX_TICKS + 1);
    localparam int PED_LAST  = (PED_MIN_GREEN > 0) ? PED_MIN_GREEN - 1 : 0;

    localparam logic [OUT_W-1:0] RESET_PIXELS = {COLOR_RED, {(OUT_W-24){1'b0}}};

    state_t           state, state_next;
    logic [CW-1:0]    cnt, last_cnt;
    logic             tick, phase_end, entering, ped_latch, started;
    logic [OUT_W-1:0] pixels_next;

    assign entering = (state_next != state);
    assign phase    = state;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (entering),
        .hold  (hold),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_INIT;
        else
            state <= state_next;
    end

    always_comb begin
        last_cnt   = CW'(BLINK_TICKS - 1);
        state_next = state;
        case (state)
            ST_INIT:       last_cnt = CW'(INIT_TICKS - 1);
            ST_GREEN:      last_cnt = CW'(GREEN_TICKS - 1);
            ST_YELLOW:     last_cnt = CW'(YELLOW_TICKS - 1);
            ST_RED:        last_cnt = CW'(RED_TICKS - 1);
            ST_RED_YELLOW: last_cnt = CW'(RED_YELLOW_TICKS - 1);
            default:       last_cnt = CW'(BLINK_TICKS - 1);
        endcase
        // A served pedestrian request may cut green short once the minimum has run.
        phase_end = tick && ((cnt == last_cnt) ||
                             (state == ST_GREEN && ped_latch && cnt >= CW'(PED_LAST)));
        if (phase_end) begin
            if (!is_day(state))
                state_next = !night_mode ? ST_INIT :
                             (state == ST_NIGHT_ON) ? ST_NIGHT_OFF : ST_NIGHT_ON;
            else if (night_mode)
                state_next = ST_NIGHT_ON;
            else begin
                case (state)
                    ST_INIT:       state_next = ST_RED;
                    ST_RED:        state_next = ST_RED_YELLOW;
                    ST_RED_YELLOW: state_next = ST_GREEN;
                    ST_GREEN:      state_next = ST_YELLOW;
                    ST_YELLOW:     state_next = ST_RED;
                    default:       state_next = ST_INIT;
                endcase
            end
        end
    end

    always_comb begin
        pixels_next = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            pixels_next[(NUM_LEDS-1-i)*24 +: 24] = lamp_color(state_next, i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            ped_latch    <= 1'b0;
            started      <= 1'b0;
            frame_update <= 1'b0;
            ped_ack      <= 1'b0;
            colordata    <= RESET_PIXELS;
        end else begin
            if (entering)
                cnt <= '0;
            else if (tick)
                cnt <= cnt + CW'(1);

            ped_ack <= entering && (state_next == ST_RED) && ped_latch;

            // Clearing on RED/night entry wins over a request arriving on that same edge.
            if (entering && (state_next == ST_RED || (state_next == ST_NIGHT_ON && is_day(state))))
                ped_latch <= 1'b0;
            else if (ped_req && state != ST_RED)
                ped_latch <= 1'b1;

            colordata    <= pixels_next;
            frame_update <= (pixels_next != colordata) || !started;
            started      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed scenarios plus randomized stimulus,
// all checked against a cycle-arithmetic reference model of the light rules.
module tb_traffic_light_ctrl;

    localparam int DIV     = 10;
    localparam int NL      = 4;
    localparam int W       = NL * 24;
    localparam int T_INIT  = 2;
    localparam int T_GREEN = 5;
    localparam int T_PMG   = 2;
    localparam int T_YEL   = 1;
    localparam int T_RED   = 3;
    localparam int T_RY    = 1;
    localparam int T_BLINK = 1;

    localparam logic [23:0] C_RED = 24'h00FF00;
    localparam logic [23:0] C_AMB = 24'hA5FF00;
    localparam logic [23:0] C_GRN = 24'hFF0000;
    localparam logic [23:0] C_OFF = 24'h000000;
    localparam logic [W-1:0] RESET_PIX = {C_RED, C_OFF, C_OFF, C_OFF};
    localparam logic [W-1:0] INIT_PIX  = {C_RED, C_OFF, C_OFF, C_RED};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic night_mode = 1'b0;
    logic ped_req = 1'b0;
    logic hold = 1'b0;
    logic [W-1:0] colordata;
    logic frame_update, ped_ack;
    logic [2:0] phase;

    always #5 clk = ~clk;

    traffic_light_ctrl #(
        .CLK_HZ(100), .TICK_HZ(10), .NUM_LEDS(NL), .INIT_TICKS(T_INIT),
        .GREEN_TICKS(T_GREEN), .PED_MIN_GREEN(T_PMG), .YELLOW_TICKS(T_YEL),
        .RED_TICKS(T_RED), .RED_YELLOW_TICKS(T_RY), .BLINK_TICKS(T_BLINK)
    ) dut (
        .clk(clk), .reset(reset), .night_mode(night_mode), .ped_req(ped_req),
        .hold(hold), .colordata(colordata), .frame_update(frame_update),
        .phase(phase), .ped_ack(ped_ack)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: state 0..6, cycles run in the current phase (hold excluded).
    int m_state, m_run;
    bit m_latch, m_started, m_fu, m_ack;
    logic [W-1:0] m_color;
    int mism, fu_seen;
    logic [W+4:0] first_act, first_exp;

    function automatic logic [W-1:0] lamps(int s);
        case (s)
            0:       return {C_RED, C_OFF, C_OFF, C_RED};
            1:       return {C_OFF, C_OFF, C_GRN, C_RED};
            2:       return {C_OFF, C_AMB, C_OFF, C_RED};
            3:       return {C_RED, C_OFF, C_OFF, C_GRN};
            4:       return {C_RED, C_AMB, C_OFF, C_RED};
            5:       return {C_OFF, C_AMB, C_OFF, C_OFF};
            default: return '0;
        endcase
    endfunction

    function automatic int dur(int s);
        case (s)
            0: return T_INIT;
            1: return T_GREEN;
            2: return T_YEL;
            3: return T_RED;
            4: return T_RY;
            default: return T_BLINK;
        endcase
    endfunction

    function automatic int succ(int s);
        case (s)
            0: return 3;
            3: return 4;
            4: return 1;
            1: return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_run = 0; m_latch = 0; m_started = 0;
        m_fu = 0; m_ack = 0; m_color = RESET_PIX;
    endtask

    task automatic model_step();
        int nxt, t;
        bit endp;
        nxt = m_state;
        endp = 0;
        if (!hold && (m_run + 1) % DIV == 0) begin
            t = (m_run + 1) / DIV;
            endp = (t == dur(m_state)) || (m_state == 1 && m_latch && t >= T_PMG);
        end
        if (endp) begin
            if (m_state >= 5) nxt = night_mode ? ((m_state == 5) ? 6 : 5) : 0;
            else              nxt = night_mode ? 5 : succ(m_state);
        end
        m_ack = (nxt == 3 && m_state != 3 && m_latch);
        if (nxt != m_state && (nxt == 3 || (nxt == 5 && m_state < 5))) m_latch = 0;
        else if (ped_req && m_state != 3) m_latch = 1;
        m_run = (nxt != m_state) ? 0 : (hold ? m_run : m_run + 1);
        m_fu = (lamps(nxt) != m_color) || !m_started;
        m_color = lamps(nxt);
        m_started = 1;
        m_state = nxt;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        if (frame_update === 1'b1) fu_seen++;
        if ({phase, colordata, frame_update, ped_ack} !== {3'(m_state), m_color, m_fu, m_ack}) begin
            if (mism == 0) begin
                first_act = {phase, colordata, frame_update, ped_ack};
                first_exp = {3'(m_state), m_color, m_fu, m_ack};
            end
            mism++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ped_req = 1'b0; night_mode = 1'b0; hold = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mism = 0; fu_seen = 0;
    endtask

    task automatic wait_phase(input int ph, input int limit, output bit ok);
        int n;
        n = 0;
        while (phase != 3'(ph) && n < limit) begin cyc(); n++; end
        ok = (phase == 3'(ph));
    endtask

    task automatic run_phase(input int limit, output int len);
        logic [2:0] ph;
        ph = phase;
        len = 0;
        while (phase == ph && len < limit) begin cyc(); len++; end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (colordata !== RESET_PIX) begin errors++; $display("FAIL reset_colordata got=%h want=%h", colordata, RESET_PIX); end
        checks++; if ({phase, frame_update, ped_ack} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got phase=%0d fu=%b ack=%b want 0/0/0", phase, frame_update, ped_ack); end
        cyc();
        checks++; if (frame_update !== 1'b1 || colordata !== INIT_PIX) begin errors++; $display("FAIL first_frame got fu=%b cd=%h want fu=1 cd=%h", frame_update, colordata, INIT_PIX); end
        cyc();
        checks++; if (frame_update !== 1'b0) begin errors++; $display("FAIL first_frame_once got=%b want=0", frame_update); end
    endtask

    task automatic test_idle_sequence();
        int exp_ph[5]  = '{0, 3, 4, 1, 2};
        int exp_len[5] = '{20, 30, 10, 50, 10};
        int len;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            checks++; if (phase !== 3'(exp_ph[k])) begin errors++; $display("FAIL idle_phase%0d got=%0d want=%0d", k, phase, exp_ph[k]); end
            run_phase(200, len);
            checks++; if (len != exp_len[k]) begin errors++; $display("FAIL idle_len%0d got=%0d want=%0d", k, len, exp_len[k]); end
        end
        checks++; if (phase !== 3'd3) begin errors++; $display("FAIL idle_back_to_red got=%0d want=3", phase); end
        checks++; if (fu_seen != 6) begin errors++; $display("FAIL idle_frame_updates got=%0d want=6", fu_seen); end
        checks++; if (mism !== 0) begin errors++; $display("FAIL idle_model cycles=%0d got=%h want=%h", mism, first_act, first_exp); end
    endtask

    task automatic test_ped_request();
        bit ok;
        int len;
        do_reset();
        wait_phase(1, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ped_reach_green got=%0d want=1", phase); end
        cyc(); cyc();
        ped_req = 1'b1; cyc(); ped_req = 1'b0;
        run_phase(200, len);
        checks++; if (len + 3 != 20) begin errors++; $display("FAIL ped_green_len got=%0d want=20", len + 3); end
        checks++; if (phase !== 3'd2) begin errors++; $display("FAIL ped_to_yellow got=%0d want=2", phase); end
        run_phase(200, len);
        checks++; if (len != 10) begin errors++; $display("FAIL ped_yellow_len got=%0d want=10", len); end
        checks++; if (phase !== 3'd3 || ped_ack !== 1'b1) begin errors++; $display("FAIL ped_ack_on_red got phase=%0d ack=%b want 3/1", phase, ped_ack); end
        checks++; if (colordata[23:0] !== C_GRN) begin errors++; $display("FAIL ped_walk_lamp got=%h want=%h", colordata[23:0], C_GRN); end
        cyc();
        checks++; if (ped_ack !== 1'b0) begin errors++; $display("FAIL ped_ack_pulse got=%b want=0", ped_ack); end
        checks++; if (mism !== 0) begin errors++; $display("FAIL ped_model cycles=%0d got=%h want=%h", mism, first_act, first_exp); end
    endtask

    task automatic test_ped_in_red();
        int len;
        do_reset();
        repeat (19) cyc();
        ped_req = 1'b1;
        cyc();
        checks++; if (phase !== 3'd3 || ped_ack !== 1'b0) begin errors++; $display("FAIL redped_entry got phase=%0d ack=%b want 3/0", phase, ped_ack); end
        run_phase(200, len);
        checks++; if (len != 30) begin errors++; $display("FAIL redped_red_len got=%0d want=30", len); end
        ped_req = 1'b0;
        run_phase(200, len);
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL redped_green got=%0d want=1", phase); end
        run_phase(200, len);
        checks++; if (len != 50) begin errors++; $display("FAIL redped_full_green got=%0d want=50", len); end
        checks++; if (mism !== 0) begin errors++; $display("FAIL redped_model cycles=%0d got=%h want=%h", mism, first_act, first_exp); end
    endtask

    task automatic test_night();
        bit ok;
        int len;
        do_reset();
        wait_phase(1, 300, ok);
        repeat (5) cyc();
        night_mode = 1'b1;
        run_phase(200, len);
        checks++; if (len + 5 != 50 || phase !== 3'd5) begin errors++; $display("FAIL night_green_done got len=%0d phase=%0d want 50/5", len + 5, phase); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (colordata[71:48] !== ((k % 2 == 0) ? C_AMB : C_OFF) || phase !== ((k % 2 == 0) ? 3'd5 : 3'd6)) begin
                errors++; $display("FAIL night_blink%0d got amber=%h phase=%0d", k, colordata[71:48], phase);
            end
            run_phase(200, len);
            checks++; if (len != 10) begin errors++; $display("FAIL night_half%0d got=%0d want=10", k, len); end
        end
        night_mode = 1'b0;
        run_phase(200, len);
        checks++; if (len != 10 || phase !== 3'd0 || colordata !== INIT_PIX) begin errors++; $display("FAIL night_exit got len=%0d phase=%0d cd=%h", len, phase, colordata); end
        run_phase(200, len);
        checks++; if (len != 20 || phase !== 3'd3) begin errors++; $display("FAIL night_allred got len=%0d phase=%0d want 20/3", len, phase); end
        checks++; if (mism !== 0) begin errors++; $display("FAIL night_model cycles=%0d got=%h want=%h", mism, first_act, first_exp); end
    endtask

    task automatic test_hold();
        bit ok, stable;
        int len, f0;
        logic [W-1:0] snap;
        do_reset();
        wait_phase(3, 300, ok);
        repeat (10) cyc();
        hold = 1'b1;
        snap = colordata; f0 = fu_seen; stable = 1;
        repeat (37) begin cyc(); if (colordata !== snap || phase !== 3'd3) stable = 0; end
        hold = 1'b0;
        checks++; if (!stable) begin errors++; $display("FAIL hold_stable got cd=%h phase=%0d want cd=%h phase=3", colordata, phase, snap); end
        checks++; if (fu_seen != f0) begin errors++; $display("FAIL hold_no_frame got=%0d want=%0d", fu_seen - f0, 0); end
        run_phase(200, len);
        checks++; if (len + 47 != 67) begin errors++; $display("FAIL hold_red_len got=%0d want=67", len + 47); end
        checks++; if (mism !== 0) begin errors++; $display("FAIL hold_model cycles=%0d got=%h want=%h", mism, first_act, first_exp); end
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        wait_phase(2, 300, ok);
        cyc();
        ped_req = 1'b1; cyc(); ped_req = 1'b0;
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (colordata !== RESET_PIX) begin errors++; $display("FAIL areset_colordata got=%h want=%h", colordata, RESET_PIX); end
        checks++; if ({phase, ped_ack, frame_update} !== 5'b0) begin errors++; $display("FAIL areset_ctrl got phase=%0d ack=%b fu=%b want 0/0/0", phase, ped_ack, frame_update); end
        @(negedge clk);
        reset = 1'b0;
        wait_phase(3, 300, ok);
        checks++; if (!ok || ped_ack !== 1'b0) begin errors++; $display("FAIL areset_latch_lost got phase=%0d ack=%b want 3/0", phase, ped_ack); end
        checks++; if (mism !== 0) begin errors++; $display("FAIL areset_model cycles=%0d got=%h want=%h", mism, first_act, first_exp); end
    endtask

    task automatic test_random();
        int night_cycles;
        do_reset();
        night_cycles = 0;
        repeat (4000) begin
            ped_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) night_mode = ~night_mode;
            hold = hold ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) == 0);
            cyc();
            if (phase >= 3'd5) night_cycles++;
        end
        ped_req = 1'b0; hold = 1'b0; night_mode = 1'b0;
        checks++; if (mism !== 0) begin errors++; $display("FAIL random_model cycles=%0d got=%h want=%h", mism, first_act, first_exp); end
        $display("random run: %0d cycles in night states", night_cycles);
    endtask

    initial begin
        model_reset();
        mism = 0; fu_seen = 0;
        test_reset();
        test_idle_sequence();
        test_ped_request();
        test_ped_in_red();
        test_night();
        test_hold();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Parametrised traffic-light sequencer with built-in phase timing, pedestrian request and night (blinking amber) mode. Builds the GRB pixel vector for the LED strip and feeds it straight to the existing bitcreator serialiser (colordata in, cled out). Replaces the fixed one-second, four-phase controller and its external timer. Lamp slot 0 (MSB) = red, 1 = amber, 2 = green, optional slot 3 = pedestrian lamp.

Parameters:
CLK_HZ, 100_000_000, clk frequency in Hz
TICK_HZ, 10, phase-timer tick rate; DIV = CLK_HZ/TICK_HZ, must be >= 2
NUM_LEDS, 4, pixels driven; must be >= 3; slot 3 = pedestrian lamp; slots >= 4 always off
INIT_TICKS, 20, all-red safety phase after reset or night exit
GREEN_TICKS, 50, full green duration
PED_MIN_GREEN, 20, minimum green before a pedestrian request cuts green short; must be <= GREEN_TICKS
YELLOW_TICKS, 10, amber duration
RED_TICKS, 50, red duration, pedestrian walk
RED_YELLOW_TICKS, 10, red+amber duration
BLINK_TICKS, 5, night-mode on/off half-period

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
night_mode  in  1  level; request blinking-amber operation
ped_req  in  1  pedestrian button; any high cycle registers a request
hold  in  1  level; freezes prescaler and phase counter (maintenance)
colordata  out  NUM_LEDS*24  GRB pixel vector, slot 0 in MSBs; to bitcreator
frame_update  out  1  one-cycle pulse when colordata changes
phase  out  3  current state encoding
ped_ack  out  1  one-cycle pulse when a latched request is served

Behaviour:
- Reset (async, active-high): state INIT, colordata = red in slot 0, all others off; prescaler and phase counter 0; ped latch 0; frame_update 0; ped_ack 0. First cycle after reset release: frame_update = 1 once.
- Timing: prescaler counts 0..DIV-1. Tick = prescaler at DIV-1. Phase counter increments on each tick. Phase ends on the tick where count = DUR-1, so every phase lasts exactly DUR*DIV cycles. Prescaler and counter clear on every state entry. hold = 1 freezes both; the state does not change except on reset.
- States: INIT(0), GREEN(1), YELLOW(2), RED(3), RED_YELLOW(4), NIGHT_ON(5), NIGHT_OFF(6).
- Day cycle: INIT -> RED -> RED_YELLOW -> GREEN -> YELLOW -> RED.
- Lamps per state:
  - INIT: red.
  - GREEN: green.
  - YELLOW: amber.
  - RED: red, plus pedestrian lamp = green (walk).
  - RED_YELLOW: red + amber.
  - NIGHT_ON: amber.
  - NIGHT_OFF: all off.
  - Pedestrian lamp is red in every state except RED and NIGHT_*; it is off in NIGHT_*.
- Output timing: colordata, phase and frame_update register on the same edge as the state change; zero added latency. frame_update pulses only if the new colordata differs from the old value.
- Pedestrian request:
  - ped_req high in any state except RED sets the latch.
  - In GREEN with the latch set, the phase ends on the tick where count >= PED_MIN_GREEN-1 (immediately at that tick if already past).
  - On entry to RED the latch clears and ped_ack pulses once.
  - ped_req during RED is ignored.
- Night mode:
  - night_mode is sampled only at day-phase end. If high, the next state is NIGHT_ON instead of the normal successor, and the ped latch clears.
  - NIGHT_ON and NIGHT_OFF alternate every BLINK_TICKS.
  - At a blink boundary with night_mode low, the next state is INIT. The day cycle always restarts through all-red.
- Simultaneous events: night beats pedestrian at the same boundary. A ped_req on the same cycle as entry to RED is ignored.
- Reset mid-phase: immediate return to INIT, latch lost.
- Colour constants (GRB): RED 24'h00FF00, AMBER 24'hA5FF00, GREEN 24'hFF0000, OFF 24'h000000.

Decomposition:
- Package traffic_pkg:
  - state enum (3-bit, codes above)
  - 24-bit colour constants
  - slot index constants SLOT_RED=0, SLOT_AMBER=1, SLOT_GREEN=2, SLOT_PED=3
- Sub-module tick_gen: prescaler with clear and hold inputs and a tick output; parameter DIV.
- The FSM, phase counter, ped latch and pixel packing stay in traffic_light_ctrl. bitcreator is instantiated by the top level, not inside this block.

Test Plan:
All tests use CLK_HZ=100, TICK_HZ=10 (DIV=10), INIT=2, GREEN=5, PED_MIN_GREEN=2, YELLOW=1, RED=3, RED_YELLOW=1, BLINK=1, NUM_LEDS=4.
1. Reset then idle -> sequence INIT 20 cycles, RED 30, RED_YELLOW 10, GREEN 50, YELLOW 10, RED; colordata matches the lamp table in each state; one frame_update per change.
2. ped_req 1-cycle pulse at GREEN cycle 3 -> GREEN ends after 20 cycles; YELLOW 10 cycles; ped_ack pulses on RED entry; slot 3 = 24'hFF0000 during RED.
3. ped_req held high through RED -> no new latch; next GREEN runs the full 50 cycles.
4. night_mode raised mid-GREEN -> GREEN completes, then slot 1 alternates AMBER/OFF every 10 cycles. Drop night_mode -> next blink boundary goes to INIT (all red) for 20 cycles, then RED.
5. hold high for 37 cycles mid-RED -> RED lasts 30+37 cycles; colordata stable; no frame_update during hold.
6. Async reset asserted mid-YELLOW between clock edges -> colordata = red pattern immediately, phase = 0, ped latch cleared, ped_ack 0.
